// File: rtl/ap_ctrl_hs_driver.sv
// ap_ctrl_hs initiator for simulation harnesses. It issues a programmed number
// of start/ready handshakes to a block, retires its done/continue completions,
// and reports per-transaction latency, the maximum latency of the run and
// sticky watchdog/protocol error flags. Start timestamps of outstanding
// transactions are queued in a small FIFO so that pipelined blocks with
// several transactions in flight are measured correctly.
module ap_ctrl_hs_driver #(
  parameter int CNT_W   = 16,
  parameter int TS_W    = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 100000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_start,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic [CNT_W-1:0] cmd_gap,
  input  logic             hold_continue,
  input  logic             dut_ap_ready,
  input  logic             dut_ap_done,
  output logic             dut_ap_start,
  output logic             dut_ap_continue,
  output logic             busy,
  output logic             finish,
  output logic [CNT_W-1:0] start_cnt,
  output logic [CNT_W-1:0] done_cnt,
  output logic [TS_W-1:0]  last_latency,
  output logic [TS_W-1:0]  max_latency,
  output logic             err_timeout,
  output logic             err_protocol
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int OCC_W = $clog2(DEPTH + 1);
  localparam int WD_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ISSUE  = 3'd1,
    S_GAP    = 3'd2,
    S_DRAIN  = 3'd3,
    S_FINISH = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] gap_q;
  logic [CNT_W-1:0] gap_cnt_q;
  logic [CNT_W-1:0] start_cnt_q;
  logic [CNT_W-1:0] done_cnt_q;
  logic [TS_W-1:0]  last_lat_q;
  logic [TS_W-1:0]  max_lat_q;
  logic             err_to_q;
  logic             err_pr_q;

  logic [TS_W-1:0]  cycle_q;
  logic [WD_W-1:0]  wd_q;

  logic [TS_W-1:0]  ts_hold_q;
  logic             ts_vld_q;

  logic [TS_W-1:0]  ts_mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [OCC_W-1:0] occ_q;

  logic             fifo_full;
  logic             fifo_empty;
  logic             accept;
  logic             retire;
  logic             push;
  logic             pop;
  logic [TS_W-1:0]  push_ts;
  logic [TS_W-1:0]  pop_lat;
  logic [CNT_W-1:0] start_cnt_inc;
  logic [CNT_W-1:0] done_cnt_nxt;
  logic             wd_expire;

  // Circular pointer advance; DEPTH need not make the pointer wrap naturally.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end
    return p + 1'b1;
  endfunction

  assign fifo_full  = (occ_q == OCC_FULL);
  assign fifo_empty = (occ_q == '0);

  // Start is a pure decode of registered state, so it is glitch-free and a
  // full FIFO holds it low before it ever rises.
  assign dut_ap_start    = (state_q == S_ISSUE) && !fifo_full;
  assign dut_ap_continue = ~hold_continue;

  assign accept  = dut_ap_start && dut_ap_ready;
  assign retire  = dut_ap_done && dut_ap_continue && (state_q != S_IDLE);
  assign push    = accept;
  assign pop     = retire && !fifo_empty;

  // A start raised and accepted in the same cycle is stamped with the current
  // cycle; a start waiting for ready keeps the stamp of its first cycle.
  assign push_ts = ts_vld_q ? ts_hold_q : cycle_q;
  assign pop_lat = cycle_q - ts_mem[rd_ptr_q];

  assign start_cnt_inc = start_cnt_q + 1'b1;
  assign done_cnt_nxt  = done_cnt_q + CNT_W'(pop);

  assign wd_expire = busy && !accept && !retire && (wd_q == WD_LAST);

  assign busy         = (state_q == S_ISSUE) || (state_q == S_GAP) || (state_q == S_DRAIN);
  assign finish       = (state_q == S_FINISH);
  assign start_cnt    = start_cnt_q;
  assign done_cnt     = done_cnt_q;
  assign last_latency = last_lat_q;
  assign max_latency  = max_lat_q;
  assign err_timeout  = err_to_q;
  assign err_protocol = err_pr_q;

  // Free-running cycle counter used as the timestamp base; wraps naturally.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_q <= '0;
    end else begin
      cycle_q <= cycle_q + 1'b1;
    end
  end

  // Hold the timestamp of a pending start until the block accepts it.
  always_ff @(posedge clock) begin
    if (reset) begin
      ts_vld_q <= 1'b0;
    end else if (accept || (state_q == S_FINISH)) begin
      ts_vld_q <= 1'b0;
    end else if (dut_ap_start && !ts_vld_q) begin
      ts_vld_q  <= 1'b1;
      ts_hold_q <= cycle_q;
    end
  end

  // Timestamp storage of outstanding transactions.
  always_ff @(posedge clock) begin
    if (push) begin
      ts_mem[wr_ptr_q] <= push_ts;
    end
  end

  // FIFO pointers and occupancy; outstanding entries are dropped on FINISH.
  always_ff @(posedge clock) begin
    if (reset || (state_q == S_FINISH)) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
      end
      if (push && !pop) begin
        occ_q <= occ_q + 1'b1;
      end else if (pop && !push) begin
        occ_q <= occ_q - 1'b1;
      end
    end
  end

  // Watchdog: cycles since the last handshake event while a run is active.
  always_ff @(posedge clock) begin
    if (reset || !busy || accept || retire) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_q + 1'b1;
    end
  end

  // Run sequencing FSM together with the run statistics it clears.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      start_cnt_q <= '0;
      done_cnt_q  <= '0;
      last_lat_q  <= '0;
      max_lat_q   <= '0;
      err_to_q    <= 1'b0;
      err_pr_q    <= 1'b0;
    end else begin
      if (accept) begin
        start_cnt_q <= start_cnt_inc;
      end
      if (pop) begin
        done_cnt_q <= done_cnt_nxt;
        last_lat_q <= pop_lat;
        if (pop_lat > max_lat_q) begin
          max_lat_q <= pop_lat;
        end
      end
      if (retire && fifo_empty) begin
        err_pr_q <= 1'b1;
      end

      case (state_q)
        S_IDLE: begin
          if (cmd_start) begin
            count_q     <= cmd_count;
            gap_q       <= cmd_gap;
            start_cnt_q <= '0;
            done_cnt_q  <= '0;
            last_lat_q  <= '0;
            max_lat_q   <= '0;
            err_to_q    <= 1'b0;
            err_pr_q    <= 1'b0;
            state_q     <= (cmd_count != '0) ? S_ISSUE : S_FINISH;
          end
        end

        S_ISSUE: begin
          if (wd_expire) begin
            err_to_q <= 1'b1;
            state_q  <= S_FINISH;
          end else if (accept) begin
            if (start_cnt_inc == count_q) begin
              state_q <= S_DRAIN;
            end else if (gap_q != '0) begin
              gap_cnt_q <= gap_q;
              state_q   <= S_GAP;
            end
          end
        end

        S_GAP: begin
          if (wd_expire) begin
            err_to_q <= 1'b1;
            state_q  <= S_FINISH;
          end else if (gap_cnt_q == CNT_W'(1)) begin
            state_q <= S_ISSUE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 1'b1;
          end
        end

        S_DRAIN: begin
          if (done_cnt_nxt == count_q) begin
            state_q <= S_FINISH;
          end else if (wd_expire) begin
            err_to_q <= 1'b1;
            state_q  <= S_FINISH;
          end
        end

        S_FINISH: begin
          state_q <= S_IDLE;
        end

        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule
